pong_game_core: RTL and testbench
=================================

# pong_game_core

Parametrised Pong game engine: two player paddles, ball motion, wall and paddle collisions, scoring and match state, plus a registered per-pixel "draw" output.

- Sits between the sync-pulse generator, which supplies the row/col counters and a per-frame tick, and the VGA colour outputs.
- Replaces the free-running single-paddle ball/paddle pair with one synchronous game state machine.
- All game state advances once per frame. Rendering runs every clock.

## Interface
- H_ACTIVE, 640: visible columns.
- V_ACTIVE, 480: visible rows.
- COORD_W, 10: coordinate width (row, col, positions).
- BALL_SIZE, 8: ball side length, pixels.
- PADDLE_W, 8: paddle width.
- PADDLE_H, 64: paddle height.
- PADDLE_XL, 16: left paddle left edge column.
- PADDLE_XR, 616: right paddle left edge column.
- PADDLE_SPEED, 4: paddle pixels per frame.
- BALL_SPEED, 2: ball pixels per frame, each axis.
- SCORE_W, 4: score counter width.
- WIN_SCORE, 9: points needed to win.
- SERVE_FRAMES, 60: frames the ball is held at centre before launch.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blanking.
- row  in  COORD_W  current pixel row.
- col  in  COORD_W  current pixel column.
- start  in  1  level; begins a match from IDLE or GAME_OVER.
- l_up, l_dn, r_up, r_dn  in  1 each  paddle buttons, synchronous level.
- pixel_on  out  1  registered: ball or a paddle covers (row, col).
- score_l, score_r  out  SCORE_W each  scores.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3.
- winner  out  1  valid in GAME_OVER; 0 = left won, 1 = right won.

## Operation
- State updates happen only on a clk edge with frame_tick=1, except the IDLE/GAME_OVER to SERVE transition, which is taken on any clk edge with start=1.
- Starting a match from IDLE or GAME_OVER:
  - Clears both scores.
  - Centres the ball at bx=(H_ACTIVE-BALL_SIZE)/2, by=(V_ACTIVE-BALL_SIZE)/2.
  - Loads serve_cnt=SERVE_FRAMES and sets serve direction to right.
- Paddles, in SERVE and PLAY, on each tick:
  - up alone: py -= PADDLE_SPEED, saturating at 0.
  - down alone: py += PADDLE_SPEED, saturating at V_ACTIVE-PADDLE_H.
  - both or neither pressed: no change.
  - Paddles hold position in IDLE and GAME_OVER.
- SERVE, per tick:
  - serve_cnt decrements.
  - On the tick where serve_cnt is 0: vx=±BALL_SPEED in the serve direction, vy=+BALL_SPEED, go to PLAY.
- PLAY, per tick: compute nx=bx+vx and ny=by+vy signed, COORD_W+2 bits, then apply in priority order:
  - Vertical bounce:
    - ny<0: by=0, vy=-vy.
    - ny>V_ACTIVE-BALL_SIZE: by=V_ACTIVE-BALL_SIZE, vy=-vy.
    - otherwise by=ny.
  - Left paddle hit, when all hold: vx<0; nx<=PADDLE_XL+PADDLE_W; nx+BALL_SIZE>PADDLE_XL; the ball vertically overlaps the left paddle (by+BALL_SIZE>pyl and by<pyl+PADDLE_H, using the pre-move by). Then bx=PADDLE_XL+PADDLE_W, vx=+BALL_SPEED.
  - Right paddle hit: mirror case, vx>0, with bx=PADDLE_XR-BALL_SIZE, vx=-BALL_SPEED.
  - nx<0: right scores; serve direction becomes left (toward the conceder).
  - nx>H_ACTIVE-BALL_SIZE: left scores; serve direction becomes right.
  - otherwise bx=nx.
- On a point:
  - The scorer's score increments.
  - If the new score equals WIN_SCORE: go to GAME_OVER, set winner. The ball stays where it is.
  - Otherwise: recentre the ball, reload serve_cnt, go to SERVE.
- Render:
  - pixel_on is registered from (row, col) every clk, in all states.
  - Ball term: col in [bx, bx+BALL_SIZE) and row in [by, by+BALL_SIZE).
  - Paddle terms: col in [PADDLE_XL or PADDLE_XR, +PADDLE_W) and row in [py, py+PADDLE_H).
- Reset values:
  - state=IDLE, scores=0, winner=0, pixel_on=0.
  - Ball centred, vx=vy=0.
  - Both paddles at (V_ACTIVE-PADDLE_H)/2.
  - serve_cnt=SERVE_FRAMES.

## Timing
- pixel_on latency: 1 clk after row/col.
- Position, score and state changes take effect on the clk edge where frame_tick=1. They are visible to the next compare cycle.
- start is acted on in 1 clk. start in SERVE or PLAY is ignored.
- A serve launch is SERVE_FRAMES+1 ticks after entering SERVE.
- Simultaneous wall bounce and paddle hit or score on the same tick: both axes are applied independently.
- frame_tick held high for several clks: each high clk is a separate tick. Integration guarantees a single-cycle pulse.
- rst_n assertion mid-frame or mid-play: immediate return to reset values. Deassertion is synchronised externally.

## Test plan
- Reset then start=1 for 1 clk -> state=SERVE. After 61 ticks -> state=PLAY, vx=+2, vy=+2, ball at (316,236).
- l_up held for 200 ticks from pyl=208 -> pyl reaches 0 and stays 0; l_up+l_dn together -> pyl unchanged.
- Ball at by=1, vy=-2, one tick -> by=0, vy=+2. Mirror at the bottom -> by=472, vy=-2.
- Left paddle pyl=200, ball bx=25, by=210, vx=-2, one tick -> bx=24, vx=+2, no score. Same with pyl=0 -> after ball passes col 0, score_r=1, state=SERVE, next serve vx=-2.
- score_l=8, left scores -> score_l=9, state=GAME_OVER, winner=0. Then start -> scores=0, state=SERVE.
- Ball at (100,50) -> pixel_on=1 one clk after (row=50,col=100) and after (57,107); pixel_on=0 after (58,107) and after (50,108).

Source files
------------

// File: rtl/pong_game_core.sv
// Pong game engine: two paddles, ball motion, wall/paddle collisions,
// scoring and match state, plus a registered per-pixel draw output.
// Game state advances once per frame_tick; rendering runs every clock.
module pong_game_core #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COORD_W      = 10,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               start,
    input  logic               l_up,
    input  logic               l_dn,
    input  logic               r_up,
    input  logic               r_dn,
    output logic               pixel_on,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [2:0]         state,
    output logic               winner
);
    localparam int SW = COORD_W + 2;
    localparam int UW = COORD_W + 1;
    localparam int CW = (SERVE_FRAMES < 1) ? 1 : $clog2(SERVE_FRAMES + 1);

    typedef logic signed [SW-1:0] sc_t;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        GAME_OVER = 3'd3
    } state_t;

    localparam logic [COORD_W-1:0] BX_CTR   = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] BY_CTR   = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] BY_MAX_U = COORD_W'(V_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0] PY_CTR   = COORD_W'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [COORD_W-1:0] PY_MAX   = COORD_W'(V_ACTIVE - PADDLE_H);
    localparam logic [COORD_W-1:0] PSPD     = COORD_W'(PADDLE_SPEED);
    localparam logic [COORD_W-1:0] BX_LHIT  = COORD_W'(PADDLE_XL + PADDLE_W);
    localparam logic [COORD_W-1:0] BX_RHIT  = COORD_W'(PADDLE_XR - BALL_SIZE);
    localparam sc_t                BSPD     = sc_t'(BALL_SPEED);
    localparam sc_t                BSZ      = sc_t'(BALL_SIZE);
    localparam sc_t                BX_MAX   = sc_t'(H_ACTIVE - BALL_SIZE);
    localparam sc_t                BY_MAX   = sc_t'(V_ACTIVE - BALL_SIZE);
    localparam sc_t                XL       = sc_t'(PADDLE_XL);
    localparam sc_t                XL_EDGE  = sc_t'(PADDLE_XL + PADDLE_W);
    localparam sc_t                XR       = sc_t'(PADDLE_XR);
    localparam sc_t                XR_EDGE  = sc_t'(PADDLE_XR + PADDLE_W);
    localparam logic [CW-1:0]      SRV_LOAD = CW'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   bx_q, bx_d, by_q, by_d;
    logic [COORD_W-1:0]   pyl_q, pyl_d, pyr_q, pyr_d;
    sc_t                  vx_q, vx_d, vy_q, vy_d;
    logic [CW-1:0]        srv_cnt_q, srv_cnt_d;
    logic                 srv_right_q, srv_right_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
    logic                 winner_q, winner_d;
    logic                 pixel_on_q, pixel_on_d;

    sc_t                  nx, ny;
    logic                 hit_l, hit_r, pt_l, pt_r;

    function automatic logic [COORD_W-1:0] paddle_next(input logic [COORD_W-1:0] py,
                                                       input logic up, input logic dn);
        paddle_next = py;
        if (up && !dn) begin
            paddle_next = (py < PSPD) ? '0 : py - PSPD;
        end else if (dn && !up) begin
            paddle_next = (py > PY_MAX - PSPD) ? PY_MAX : py + PSPD;
        end
    endfunction

    // Next game state: start handling, paddle moves, serve countdown, ball physics, scoring
    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        pyl_d       = pyl_q;
        pyr_d       = pyr_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        srv_cnt_d   = srv_cnt_q;
        srv_right_d = srv_right_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        pt_l        = 1'b0;
        pt_r        = 1'b0;

        nx = $signed({2'b00, bx_q}) + vx_q;
        ny = $signed({2'b00, by_q}) + vy_q;

        // Paddle overlap uses the pre-move ball row.
        hit_l = vx_q[SW-1] && (nx <= XL_EDGE) && (nx + BSZ > XL) &&
                ({1'b0, by_q} + UW'(BALL_SIZE) > {1'b0, pyl_q}) &&
                ({1'b0, by_q} < {1'b0, pyl_q} + UW'(PADDLE_H));
        hit_r = !vx_q[SW-1] && (vx_q != '0) && (nx + BSZ >= XR) && (nx < XR_EDGE) &&
                ({1'b0, by_q} + UW'(BALL_SIZE) > {1'b0, pyr_q}) &&
                ({1'b0, by_q} < {1'b0, pyr_q} + UW'(PADDLE_H));

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    bx_d        = BX_CTR;
                    by_d        = BY_CTR;
                    srv_cnt_d   = SRV_LOAD;
                    srv_right_d = 1'b1;
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    pyl_d = paddle_next(pyl_q, l_up, l_dn);
                    pyr_d = paddle_next(pyr_q, r_up, r_dn);
                    if (srv_cnt_q == '0) begin
                        vx_d    = srv_right_q ? BSPD : -BSPD;
                        vy_d    = BSPD;
                        state_d = PLAY;
                    end else begin
                        srv_cnt_d = srv_cnt_q - CW'(1);
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    pyl_d = paddle_next(pyl_q, l_up, l_dn);
                    pyr_d = paddle_next(pyr_q, r_up, r_dn);

                    if (ny[SW-1]) begin
                        by_d = '0;
                        vy_d = -vy_q;
                    end else if (ny > BY_MAX) begin
                        by_d = BY_MAX_U;
                        vy_d = -vy_q;
                    end else begin
                        by_d = ny[COORD_W-1:0];
                    end

                    if (hit_l) begin
                        bx_d = BX_LHIT;
                        vx_d = BSPD;
                    end else if (hit_r) begin
                        bx_d = BX_RHIT;
                        vx_d = -BSPD;
                    end else if (nx[SW-1]) begin
                        pt_r        = 1'b1;
                        srv_right_d = 1'b0;
                    end else if (nx > BX_MAX) begin
                        pt_l        = 1'b1;
                        srv_right_d = 1'b1;
                    end else begin
                        bx_d = nx[COORD_W-1:0];
                    end

                    if (pt_l) score_l_d = score_l_q + SCORE_W'(1);
                    if (pt_r) score_r_d = score_r_q + SCORE_W'(1);

                    // A winning point freezes the ball; any other point recentres it.
                    if ((pt_l && score_l_d == WIN) || (pt_r && score_r_d == WIN)) begin
                        state_d  = GAME_OVER;
                        winner_d = pt_r;
                    end else if (pt_l || pt_r) begin
                        bx_d      = BX_CTR;
                        by_d      = BY_CTR;
                        srv_cnt_d = SRV_LOAD;
                        state_d   = SERVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel coverage for the current (row, col) against ball and both paddles
    always_comb begin
        logic [UW-1:0] rw, cw;
        rw = {1'b0, row};
        cw = {1'b0, col};
        pixel_on_d =
            ((cw >= {1'b0, bx_q}) && (cw < {1'b0, bx_q} + UW'(BALL_SIZE)) &&
             (rw >= {1'b0, by_q}) && (rw < {1'b0, by_q} + UW'(BALL_SIZE))) ||
            ((cw >= UW'(PADDLE_XL)) && (cw < UW'(PADDLE_XL + PADDLE_W)) &&
             (rw >= {1'b0, pyl_q}) && (rw < {1'b0, pyl_q} + UW'(PADDLE_H))) ||
            ((cw >= UW'(PADDLE_XR)) && (cw < UW'(PADDLE_XR + PADDLE_W)) &&
             (rw >= {1'b0, pyr_q}) && (rw < {1'b0, pyr_q} + UW'(PADDLE_H)));
    end

    // Game state registers and registered draw output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bx_q        <= BX_CTR;
            by_q        <= BY_CTR;
            pyl_q       <= PY_CTR;
            pyr_q       <= PY_CTR;
            vx_q        <= '0;
            vy_q        <= '0;
            srv_cnt_q   <= SRV_LOAD;
            srv_right_q <= 1'b1;
            score_l_q   <= '0;
            score_r_q   <= '0;
            winner_q    <= 1'b0;
            pixel_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            pyl_q       <= pyl_d;
            pyr_q       <= pyr_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            srv_cnt_q   <= srv_cnt_d;
            srv_right_q <= srv_right_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_q    <= winner_d;
            pixel_on_q  <= pixel_on_d;
        end
    end

    assign pixel_on = pixel_on_q;
    assign score_l  = score_l_q;
    assign score_r  = score_r_q;
    assign state    = state_q;
    assign winner   = winner_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Self-checking bench for pong_game_core: reset-state pixel table, a
// behavioural game model driving a pixel scoreboard, and hand-derived
// sequences for serve launch, paddle saturation, bounces and scoring.
module tb_pong_game_core;
    logic       clk = 1'b0;
    logic       rst_n, frame_tick, start;
    logic       l_up, l_dn, r_up, r_dn;
    logic [9:0] row, col;
    logic       pixel_on;
    logic [3:0] score_l, score_r;
    logic [2:0] state;
    logic       winner;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    // behavioural model of the game
    int mbx, mby, mvx, mvy, mpl, mpr, mst, msl, msr, mwin, mcnt, mdir;

    typedef struct {
        int    r;
        int    c;
        int    e;
        string nm;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    pong_game_core #(
        .H_ACTIVE(640), .V_ACTIVE(480), .COORD_W(10), .BALL_SIZE(8),
        .PADDLE_W(8), .PADDLE_H(64), .PADDLE_XL(16), .PADDLE_XR(616),
        .PADDLE_SPEED(4), .BALL_SPEED(2), .SCORE_W(4), .WIN_SCORE(9),
        .SERVE_FRAMES(60)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .row(row), .col(col),
        .start(start), .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
        .pixel_on(pixel_on), .score_l(score_l), .score_r(score_r),
        .state(state), .winner(winner)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mbx = 316; mby = 236; mvx = 0; mvy = 0;
        mpl = 208; mpr = 208; mst = 0; msl = 0; msr = 0;
        mwin = 0; mcnt = 60; mdir = 1;
    endfunction

    function automatic int mpix(input int r, input int c);
        bit b, pl, pr;
        b  = (c >= mbx) && (c < mbx + 8) && (r >= mby) && (r < mby + 8);
        pl = (c >= 16) && (c < 24) && (r >= mpl) && (r < mpl + 64);
        pr = (c >= 616) && (c < 624) && (r >= mpr) && (r < mpr + 64);
        return (b || pl || pr) ? 1 : 0;
    endfunction

    function automatic int pmove(input int p, input bit up, input bit dn);
        if (up && !dn) return (p < 4) ? 0 : p - 4;
        if (dn && !up) return (p > 412) ? 416 : p + 4;
        return p;
    endfunction

    function automatic void model_edge(input bit tk, input bit st);
        int nx, ny, nbx, nby, nvx, nvy, pt;
        bit lh, rh;
        if ((mst == 0 || mst == 3) && st) begin
            msl = 0; msr = 0; mbx = 316; mby = 236; mcnt = 60; mdir = 1; mst = 1;
            return;
        end
        if (!tk) return;
        if (mst == 1) begin
            mpl = pmove(mpl, l_up, l_dn);
            mpr = pmove(mpr, r_up, r_dn);
            if (mcnt == 0) begin
                mvx = mdir ? 2 : -2; mvy = 2; mst = 2;
            end else begin
                mcnt--;
            end
        end else if (mst == 2) begin
            nx = mbx + mvx; ny = mby + mvy;
            nvy = mvy;
            if (ny < 0) begin nby = 0; nvy = -mvy; end
            else if (ny > 472) begin nby = 472; nvy = -mvy; end
            else nby = ny;
            lh = (mvx < 0) && (nx <= 24) && (nx + 8 > 16) && (mby + 8 > mpl) && (mby < mpl + 64);
            rh = (mvx > 0) && (nx + 8 >= 616) && (nx < 624) && (mby + 8 > mpr) && (mby < mpr + 64);
            nbx = mbx; nvx = mvx; pt = 0;
            if (lh) begin nbx = 24; nvx = 2; end
            else if (rh) begin nbx = 608; nvx = -2; end
            else if (nx < 0) begin pt = 2; mdir = 0; end
            else if (nx > 632) begin pt = 1; mdir = 1; end
            else nbx = nx;
            mpl = pmove(mpl, l_up, l_dn);
            mpr = pmove(mpr, r_up, r_dn);
            mbx = nbx; mby = nby; mvx = nvx; mvy = nvy;
            if (pt == 1) msl++;
            if (pt == 2) msr++;
            if (pt != 0) begin
                if (msl == 9 || msr == 9) begin
                    mst = 3; mwin = (pt == 2) ? 1 : 0;
                end else begin
                    mbx = 316; mby = 236; mcnt = 60; mst = 1;
                end
            end
        end
    endfunction

    // One clock: drive at negedge, optional pixel expectation pushed
    // (-1 = from model, >=0 = given constant, -2 = none), compare after posedge.
    task automatic cyc(input bit tk, input int r, input int c, input int pexp, input string nm);
        @(negedge clk);
        frame_tick = tk;
        row = 10'(r);
        col = 10'(c);
        if (pexp == -1) exp_q.push_back(mpix(r, c));
        else if (pexp >= 0) exp_q.push_back(pexp);
        @(posedge clk);
        model_edge(tk, start);
        #1;
        frame_tick = 1'b0;
        if (pexp != -2) begin
            int e;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s scoreboard empty", nm);
            end else begin
                e = exp_q.pop_front();
                check(nm, int'(pixel_on), e);
            end
        end
        check("state", int'(state), mst);
        check("score_l", int'(score_l), msl);
        check("score_r", int'(score_r), msr);
        if (mst == 3) check("winner", int'(winner), mwin);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 0, 0, -2, "");
            cyc(1'b0, mby, mbx, -1, "ball_in");
            cyc(1'b0, mby + 8, mbx + 7, -1, "ball_below");
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < 16; i++) cyc(1'b0, tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].nm);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        tbl[0]  = '{236, 316, 1, "rst_ball_tl"};
        tbl[1]  = '{243, 323, 1, "rst_ball_br"};
        tbl[2]  = '{244, 323, 0, "rst_ball_below"};
        tbl[3]  = '{236, 324, 0, "rst_ball_right"};
        tbl[4]  = '{235, 316, 0, "rst_ball_above"};
        tbl[5]  = '{236, 315, 0, "rst_ball_left"};
        tbl[6]  = '{208, 16, 1, "rst_lpad_tl"};
        tbl[7]  = '{271, 23, 1, "rst_lpad_br"};
        tbl[8]  = '{272, 16, 0, "rst_lpad_below"};
        tbl[9]  = '{208, 24, 0, "rst_lpad_right"};
        tbl[10] = '{207, 16, 0, "rst_lpad_above"};
        tbl[11] = '{208, 616, 1, "rst_rpad_tl"};
        tbl[12] = '{271, 623, 1, "rst_rpad_br"};
        tbl[13] = '{208, 624, 0, "rst_rpad_right"};
        tbl[14] = '{240, 615, 0, "rst_rpad_left"};
        tbl[15] = '{0, 0, 0, "rst_origin"};

        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
        row = '0; col = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_score_l", int'(score_l), 0);
        check("rst_score_r", int'(score_r), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_pixel", int'(pixel_on), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_table();

        // start -> SERVE, launch after SERVE_FRAMES+1 ticks
        start = 1'b1;
        cyc(1'b0, 0, 0, -2, "");
        start = 1'b0;
        check("start_serve", int'(state), 1);
        tick_n(60);
        check("serve_hold60", int'(state), 1);
        tick_n(1);
        check("serve_launch", int'(state), 2);
        cyc(1'b0, 236, 316, 1, "launch_pos");
        tick_n(1);
        cyc(1'b0, 238, 318, 1, "vel_tl");
        cyc(1'b0, 237, 318, 0, "vel_above");
        cyc(1'b0, 238, 317, 0, "vel_left");

        // left paddle saturates at the top
        l_up = 1'b1;
        tick_n(200);
        cyc(1'b0, 0, 16, 1, "lpad_top");
        cyc(1'b0, 63, 23, 1, "lpad_top_br");
        cyc(1'b0, 64, 16, 0, "lpad_top_below");
        l_up = 1'b0; l_dn = 1'b1;
        tick_n(10);
        l_up = 1'b1;
        tick_n(20);
        cyc(1'b0, 40, 16, 1, "lpad_both_tl");
        cyc(1'b0, 39, 16, 0, "lpad_both_above");
        cyc(1'b0, 103, 16, 1, "lpad_both_bot");
        cyc(1'b0, 104, 16, 0, "lpad_both_below");
        l_up = 1'b0; l_dn = 1'b0;

        // right paddle parked at top: left wins every point
        r_up = 1'b1;
        budget = 6000;
        while (mst != 3 && budget > 0) begin
            tick_n(1);
            budget--;
        end
        check("go_state", int'(state), 3);
        check("go_score_l", int'(score_l), 9);
        check("go_winner", int'(winner), 0);
        start = 1'b1;
        cyc(1'b0, 0, 0, -2, "");
        start = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_score_l", int'(score_l), 0);
        check("restart_score_r", int'(score_r), 0);

        // right paddle at bottom returns the ball; left at top misses
        r_up = 1'b0; r_dn = 1'b1; l_up = 1'b1;
        budget = 2000;
        while (msr == 0 && budget > 0) begin
            tick_n(1);
            budget--;
        end
        check("rscore_score_r", int'(score_r), 1);
        check("rscore_state", int'(state), 1);
        tick_n(61);
        check("serve_left_play", int'(state), 2);
        tick_n(1);
        cyc(1'b0, 238, 314, 1, "serve_left_tl");
        cyc(1'b0, 238, 322, 0, "serve_left_right");
        cyc(1'b0, 238, 313, 0, "serve_left_left");

        // left paddle drops to the bottom and returns the ball near the bottom wall
        l_up = 1'b0; l_dn = 1'b1;
        tick_n(145);
        cyc(1'b0, 418, 24, 1, "lhit_pos");
        cyc(1'b0, 418, 32, 0, "lhit_right");
        cyc(1'b0, 417, 24, 0, "lhit_above");
        check("lhit_state", int'(state), 2);
        check("lhit_score_r", int'(score_r), 1);
        tick_n(100);

        // asynchronous reset in the middle of play
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("arst_state", int'(state), 0);
        check("arst_score_r", int'(score_r), 0);
        check("arst_pixel", int'(pixel_on), 0);
        l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
